mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the LC-3 datapath: serves read/write requests issued from the CPU's MAR/MDR pair. It performs a multi-cycle access to the external 16-bit SRAM, or to the memory-mapped I/O register at IO_ADDR (switches in, hex display out). It returns read data to the MDR input mux and pulses a ready strobe that the CPU control FSM waits on.

## Interface
- WAIT_CYCLES, 2: extra SRAM access cycles beyond the first (range 0–15)
- IO_ADDR, 16'hFFFF: address decoded as the I/O register instead of SRAM
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Rd_Req  in  1  read request level from CPU control; held until Ready seen
- Wr_Req  in  1  write request level from CPU control; held until Ready seen
- ADDR  in  16  address from MAR
- Data_from_CPU  in  16  write data from MDR
- SW  in  16  board switches, read at IO_ADDR
- Data_to_CPU  out  16  read data to MDR input mux; holds last read value
- Ready  out  1  one-cycle completion pulse
- HEX_Val  out  16  hex display register, written at IO_ADDR
- SRAM_ADDR  out  20  SRAM address, {4'h0, latched ADDR}
- SRAM_DQ_in  in  16  SRAM data bus, input side
- SRAM_DQ_out  out  16  SRAM data bus, output side (latched write data)
- SRAM_DQ_OE  out  1  1 = drive SRAM data bus (tristate enable at top level)
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  active-low SRAM controls

## Operation
- States: IDLE, ACCESS, DONE, RELEASE.
- IDLE:
  - If Rd_Req or Wr_Req is high, latch ADDR, Data_from_CPU, and op (write if Wr_Req, so Wr_Req wins when both are high).
  - Load wait counter with WAIT_CYCLES.
  - Go to DONE if ADDR == IO_ADDR, else ACCESS.
- ACCESS:
  - SRAM_CE_N = 0.
  - Read: SRAM_OE_N = 0, SRAM_WE_N = 1, SRAM_DQ_OE = 0.
  - Write: SRAM_WE_N = 0, SRAM_OE_N = 1, SRAM_DQ_OE = 1.
  - Counter decrements each cycle; on the cycle the counter is 0, a read captures SRAM_DQ_in into Data_to_CPU; go to DONE.
- DONE:
  - Ready = 1 for exactly this cycle.
  - SRAM_CE_N = 1, SRAM_OE_N = 1, SRAM_WE_N = 1.
  - For a write, SRAM_DQ_OE stays 1 this cycle (data hold time), then drops.
  - I/O read: Data_to_CPU <= SW (sampled on the IDLE→DONE edge).
  - I/O write: HEX_Val <= latched data on the same edge.
  - Go to RELEASE.
- RELEASE: wait until Rd_Req = 0 and Wr_Req = 0, then go to IDLE. A request held across Ready is never served twice.
- All outputs are registered or pure decodes of the state register; no combinational path from any input to any output.
- SRAM_ADDR and SRAM_DQ_out are stable from the first ACCESS cycle through DONE.
- I/O accesses never assert SRAM_CE_N, SRAM_OE_N, or SRAM_WE_N.

## Timing
- Reset (sampled at the edge) forces:
  - state IDLE
  - Data_to_CPU = 0, HEX_Val = 0, Ready = 0
  - SRAM_ADDR = 0, SRAM_DQ_OE = 0
  - SRAM_CE_N = SRAM_OE_N = SRAM_WE_N = 1
- Reset mid-access aborts the access with no Ready pulse; controls are inactive from the next cycle.
- Request sampled high in IDLE at edge 0:
  - SRAM access: ACCESS during cycles 1..WAIT_CYCLES+1; Ready high during cycle WAIT_CYCLES+2. Latency is 4 cycles at the default.
  - I/O access: Ready high during cycle 1.
- Data_to_CPU is valid in the Ready cycle and holds until the next read completes; writes never change it.
- Minimum spacing between Ready pulses: SRAM latency + 2 cycles (RELEASE + IDLE).
- Request changes during ACCESS/DONE are ignored; the latched values are used.
- WAIT_CYCLES = 0: ACCESS lasts exactly one cycle.

## Test plan
- Reset, then idle with no requests → all outputs at reset values; Ready never pulses over 20 cycles.
- SRAM write: ADDR = 16'h0010, data 16'hBEEF, Wr_Req held → SRAM_WE_N low for 3 cycles with SRAM_ADDR = 20'h00010 and SRAM_DQ_out = 16'hBEEF. Ready pulses in cycle 4.
- SRAM read: ADDR = 16'h0010, model returns 16'hBEEF, Rd_Req held 10 cycles → exactly one Ready pulse in cycle 4. Data_to_CPU = 16'hBEEF, still 16'hBEEF after Rd_Req drops.
- I/O: SW = 16'h1234, read at 16'hFFFF → Ready in cycle 1, Data_to_CPU = 16'h1234, no SRAM control asserted. A following write of 16'h00A5 at 16'hFFFF → HEX_Val = 16'h00A5.
- Rd_Req and Wr_Req both high at ADDR = 16'h0020 → a write is performed (SRAM_WE_N low) and Data_to_CPU is unchanged.
- Reset asserted in the second ACCESS cycle of a read → no Ready pulse; SRAM_CE_N = 1 and Data_to_CPU = 0 next cycle.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: serves CPU MAR/MDR read/write requests against an external
// 16-bit SRAM (multi-cycle, WAIT_CYCLES extra cycles) or the memory-mapped
// switch/hex I/O register at IO_ADDR. Ready pulses for one cycle on completion.
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Rd_Req,
  input  logic        Wr_Req,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] SW,
  output logic [15:0] Data_to_CPU,
  output logic        Ready,
  output logic [15:0] HEX_Val,
  output logic [19:0] SRAM_ADDR,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_OE,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t      state, next_state;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        wr_q;
  logic        io_q;
  logic [3:0]  cnt;
  logic        req;
  logic        io_hit;

  assign req         = Rd_Req | Wr_Req;
  assign io_hit      = (ADDR == IO_ADDR);
  assign SRAM_ADDR   = {4'h0, addr_q};
  assign SRAM_DQ_out = wdata_q;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and SRAM control decode from the registered state/op
  always_comb begin
    next_state = state;
    Ready      = 1'b0;
    SRAM_CE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_WE_N  = 1'b1;
    SRAM_DQ_OE = 1'b0;
    case (state)
      IDLE: begin
        if (req) next_state = io_hit ? DONE : ACCESS;
      end
      ACCESS: begin
        SRAM_CE_N  = 1'b0;
        SRAM_OE_N  = wr_q;
        SRAM_WE_N  = ~wr_q;
        SRAM_DQ_OE = wr_q;
        if (cnt == 4'd0) next_state = DONE;
      end
      DONE: begin
        Ready      = 1'b1;
        // write data held one extra cycle on the bus after WE_N rises
        SRAM_DQ_OE = wr_q & ~io_q;
        next_state = RELEASE;
      end
      RELEASE: begin
        if (!req) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latching, wait counter, read-data capture and I/O register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      io_q        <= 1'b0;
      cnt         <= '0;
      Data_to_CPU <= '0;
      HEX_Val     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= ADDR;
            wdata_q <= Data_from_CPU;
            wr_q    <= Wr_Req;
            io_q    <= io_hit;
            cnt     <= 4'(WAIT_CYCLES);
            if (io_hit) begin
              if (Wr_Req) HEX_Val     <= Data_from_CPU;
              else        Data_to_CPU <= SW;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!wr_q) Data_to_CPU <= SRAM_DQ_in;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a small behavioural SRAM model.
module tb_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Rd_Req = 1'b0;
  logic        Wr_Req = 1'b0;
  logic [15:0] ADDR = '0;
  logic [15:0] Data_from_CPU = '0;
  logic [15:0] SW = '0;
  logic [15:0] Data_to_CPU;
  logic        Ready;
  logic [15:0] HEX_Val;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_in;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_OE;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  mem_responder #(.WAIT_CYCLES(2), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .Rd_Req(Rd_Req), .Wr_Req(Wr_Req),
    .ADDR(ADDR), .Data_from_CPU(Data_from_CPU), .SW(SW),
    .Data_to_CPU(Data_to_CPU), .Ready(Ready), .HEX_Val(HEX_Val),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_out(SRAM_DQ_out),
    .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 Clk = ~Clk;

  // SRAM model: asynchronous read while OE_N low, write on clock while WE_N low
  assign SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[7:0]] : 16'h0000;
  always @(posedge Clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR[7:0]] <= SRAM_DQ_out;
  end

  task automatic idle_cycles(input int n);
    Rd_Req = 1'b0;
    Wr_Req = 1'b0;
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  task automatic test_reset();
    int rdy = 0;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if ({Data_to_CPU, HEX_Val, Ready} !== {16'h0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_data: got D=%h H=%h R=%b want 0 0 0", Data_to_CPU, HEX_Val, Ready);
    end
    checks++;
    if ({SRAM_ADDR, SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N} !== {20'h0, 1'b0, 3'b111}) begin
      errors++;
      $display("FAIL reset_sram: got A=%h OE=%b CE/OE/WE=%b%b%b want 0 0 111",
               SRAM_ADDR, SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Ready) rdy++;
    end
    checks++;
    if (rdy !== 0) begin
      errors++;
      $display("FAIL idle_ready: got %0d pulses want 0", rdy);
    end
  endtask

  task automatic test_sram_write();
    int we_low = 0, rdy_cyc = 0, bad_addr = 0, bad_dq = 0;
    logic oe_done = 1'b0;
    ADDR = 16'h0010;
    Data_from_CPU = 16'hBEEF;
    Wr_Req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      if (c == 2) begin
        // inputs change mid-access; latched values must be used
        ADDR = 16'h0077;
        Data_from_CPU = 16'h0000;
      end
      if (!SRAM_WE_N) begin
        we_low++;
        if (SRAM_ADDR !== 20'h00010) bad_addr++;
        if (SRAM_DQ_out !== 16'hBEEF || SRAM_DQ_OE !== 1'b1) bad_dq++;
      end
      if (Ready) begin
        rdy_cyc = c;
        oe_done = SRAM_DQ_OE;
      end
    end
    checks++;
    if (we_low !== 3) begin
      errors++;
      $display("FAIL wr_we_cycles: got %0d want 3", we_low);
    end
    checks++;
    if (bad_addr !== 0 || bad_dq !== 0) begin
      errors++;
      $display("FAIL wr_bus: bad addr cycles %0d bad data cycles %0d want 0 0", bad_addr, bad_dq);
    end
    checks++;
    if (rdy_cyc !== 4) begin
      errors++;
      $display("FAIL wr_ready_cycle: got %0d want 4", rdy_cyc);
    end
    checks++;
    if (oe_done !== 1'b1) begin
      errors++;
      $display("FAIL wr_dq_hold: got %b want 1", oe_done);
    end
    idle_cycles(2);
    checks++;
    if (SRAM_DQ_OE !== 1'b0 || mem[8'h10] !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_after: got OE=%b mem=%h want 0 beef", SRAM_DQ_OE, mem[8'h10]);
    end
  endtask

  task automatic test_sram_read();
    int rdy = 0, rdy_cyc = 0, oe_low = 0;
    logic [15:0] d_at_rdy = '0;
    ADDR = 16'h0010;
    Rd_Req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (!SRAM_OE_N) oe_low++;
      if (Ready) begin
        rdy++;
        rdy_cyc = c;
        d_at_rdy = Data_to_CPU;
      end
    end
    checks++;
    if (rdy !== 1 || rdy_cyc !== 4) begin
      errors++;
      $display("FAIL rd_ready: got %0d pulses at cycle %0d want 1 at 4", rdy, rdy_cyc);
    end
    checks++;
    if (oe_low !== 3) begin
      errors++;
      $display("FAIL rd_oe_cycles: got %0d want 3", oe_low);
    end
    checks++;
    if (d_at_rdy !== 16'hBEEF) begin
      errors++;
      $display("FAIL rd_data: got %h want beef", d_at_rdy);
    end
    idle_cycles(3);
    checks++;
    if (Data_to_CPU !== 16'hBEEF) begin
      errors++;
      $display("FAIL rd_hold: got %h want beef", Data_to_CPU);
    end
  endtask

  task automatic test_io();
    int rdy_cyc = 0, ctrl = 0;
    SW = 16'h1234;
    ADDR = 16'hFFFF;
    Rd_Req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      if (!SRAM_CE_N || !SRAM_OE_N || !SRAM_WE_N || SRAM_DQ_OE) ctrl++;
      if (Ready && rdy_cyc == 0) rdy_cyc = c;
    end
    checks++;
    if (rdy_cyc !== 1 || Data_to_CPU !== 16'h1234) begin
      errors++;
      $display("FAIL io_read: got ready cycle %0d data %h want 1 1234", rdy_cyc, Data_to_CPU);
    end
    idle_cycles(2);
    rdy_cyc = 0;
    Data_from_CPU = 16'h00A5;
    Wr_Req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      if (!SRAM_CE_N || !SRAM_OE_N || !SRAM_WE_N || SRAM_DQ_OE) ctrl++;
      if (Ready && rdy_cyc == 0) rdy_cyc = c;
    end
    checks++;
    if (rdy_cyc !== 1 || HEX_Val !== 16'h00A5 || Data_to_CPU !== 16'h1234) begin
      errors++;
      $display("FAIL io_write: got ready cycle %0d hex %h data %h want 1 00a5 1234",
               rdy_cyc, HEX_Val, Data_to_CPU);
    end
    checks++;
    if (ctrl !== 0) begin
      errors++;
      $display("FAIL io_no_sram: got %0d active control cycles want 0", ctrl);
    end
    idle_cycles(2);
  endtask

  task automatic test_both_requests();
    int we_low = 0, oe_low = 0;
    ADDR = 16'h0020;
    Data_from_CPU = 16'h5A5A;
    Rd_Req = 1'b1;
    Wr_Req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      if (!SRAM_WE_N) we_low++;
      if (!SRAM_OE_N) oe_low++;
    end
    checks++;
    if (we_low !== 3 || oe_low !== 0) begin
      errors++;
      $display("FAIL both_is_write: got we %0d oe %0d want 3 0", we_low, oe_low);
    end
    checks++;
    if (Data_to_CPU !== 16'h1234 || mem[8'h20] !== 16'h5A5A) begin
      errors++;
      $display("FAIL both_data: got D=%h mem=%h want 1234 5a5a", Data_to_CPU, mem[8'h20]);
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_abort();
    int rdy = 0;
    ADDR = 16'h0010;
    Rd_Req = 1'b1;
    @(negedge Clk);            // cycle 1: first ACCESS cycle
    @(negedge Clk);            // cycle 2: second ACCESS cycle
    checks++;
    if (SRAM_CE_N !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_access: got CE_N %b want 0", SRAM_CE_N);
    end
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (SRAM_CE_N !== 1'b1 || Data_to_CPU !== 16'h0000 || Ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: got CE_N %b D=%h R=%b want 1 0000 0", SRAM_CE_N, Data_to_CPU, Ready);
    end
    Rd_Req = 1'b0;
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (Ready) rdy++;
    end
    checks++;
    if (rdy !== 0) begin
      errors++;
      $display("FAIL abort_no_ready: got %0d pulses want 0", rdy);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_sram_write();
    test_sram_read();
    test_io();
    test_both_requests();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
